// File: rtl/uart_pkg.sv
// Shared UART definitions: frame-state encodings, default line rates and the
// bit-period helper used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } uart_state_e;

  localparam int unsigned DEFAULT_CLOCK_FREQ = 27_000_000;
  localparam int unsigned DEFAULT_BAUD_RATE  = 1_000_000;

  function automatic int unsigned clks_per_bit(input int unsigned clock_freq,
                                               input int unsigned baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input; the reset value
// is the input's idle level so no false edge is seen when reset releases.
module uart_sync2 #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its source; blocking here would collapse the two stages.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 with optional even parity, mid-bit sampling, one-cycle
// valid strobe and per-frame parity/framing error flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = DEFAULT_CLOCK_FREQ,
  parameter int unsigned BAUD_RATE  = DEFAULT_BAUD_RATE,
  parameter bit          PARITY_EN  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int          CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);

  logic rx_s;

  uart_sync2 #(.RESET_VALUE(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (Rx),
    .q   (rx_s)
  );

  uart_state_e      state, state_next;
  logic [CNT_W-1:0] clk_cnt, clk_cnt_next;
  logic [2:0]       bit_idx, bit_idx_next;
  logic [7:0]       shift_reg, shift_reg_next;
  logic             par_err, par_err_next;
  logic             load;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      par_err   <= 1'b0;
    end else begin
      state     <= state_next;
      clk_cnt   <= clk_cnt_next;
      bit_idx   <= bit_idx_next;
      shift_reg <= shift_reg_next;
      par_err   <= par_err_next;
    end
  end

  // NOTE: every signal written below gets its hold value first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_next     = state;
    clk_cnt_next   = clk_cnt;
    bit_idx_next   = bit_idx;
    shift_reg_next = shift_reg;
    par_err_next   = par_err;
    load           = 1'b0;

    case (state)
      IDLE: begin
        clk_cnt_next = '0;
        if (!rx_s) state_next = START;
      end

      // Re-check the start bit at its midpoint to reject short glitches.
      START: begin
        if (clk_cnt == CNT_HALF) begin
          clk_cnt_next = '0;
          if (!rx_s) begin
            state_next   = DATA;
            bit_idx_next = '0;
          end else begin
            state_next = IDLE;
          end
        end else begin
          clk_cnt_next = CNT_W'(clk_cnt + 1'b1);
        end
      end

      DATA: begin
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_next   = '0;
          shift_reg_next = {rx_s, shift_reg[7:1]};
          bit_idx_next   = 3'(bit_idx + 3'd1);
          if (bit_idx == 3'd7) state_next = PARITY_EN ? PARITY : STOP;
        end else begin
          clk_cnt_next = CNT_W'(clk_cnt + 1'b1);
        end
      end

      PARITY: begin
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_next = '0;
          par_err_next = rx_s ^ (^shift_reg);
          state_next   = STOP;
        end else begin
          clk_cnt_next = CNT_W'(clk_cnt + 1'b1);
        end
      end

      // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start.
      STOP: begin
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_next = '0;
          load         = 1'b1;
          state_next   = rx_s ? IDLE : BREAK;
        end else begin
          clk_cnt_next = CNT_W'(clk_cnt + 1'b1);
        end
      end

      BREAK: begin
        if (rx_s) state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= load;
      if (load) begin
        data_out   <= shift_reg;
        parity_err <= PARITY_EN & par_err;
        frame_err  <= ~rx_s;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are serialized onto Rx, expected results
// are queued at send time and compared when data_valid strobes.
module tb_uart_rx;

  localparam int CPB       = 27;
  localparam int HALF      = CPB / 2;
  localparam int FRAME_CLK = 11 * CPB;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       Rx  = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   strobe_cnt = 0;
  int   strobe_cyc[$];
  exp_t sb[$];
  logic prev_valid = 1'b0;
  int   start_cyc;

  uart_rx dut (
    .clk        (clk),
    .rst        (rst),
    .Rx         (Rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every strobe must match the oldest queued frame.
  always @(negedge clk) begin
    if (data_valid) begin
      exp_t e;
      strobe_cnt++;
      strobe_cyc.push_back(cyc);
      check("valid_one_cycle", {31'd0, prev_valid}, 32'd0);
      check("strobe_expected", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("data_out", {24'd0, data_out}, {24'd0, e.data});
        check("parity_err", {31'd0, parity_err}, {31'd0, e.perr});
        check("frame_err", {31'd0, frame_err}, {31'd0, e.ferr});
      end
    end
    prev_valid = data_valid;
  end

  task automatic drive_bit(input logic b);
    Rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_bit, input logic stop_bit);
    exp_t e;
    e.data = d;
    e.perr = par_bit ^ (^d);
    e.ferr = ~stop_bit;
    sb.push_back(e);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(par_bit);
    drive_bit(stop_bit);
  endtask

  task automatic wait_strobes(input string tag, input int target);
    int k = 0;
    while (strobe_cnt < target && k < 500) begin
      @(posedge clk);
      #1;
      k++;
    end
    check(tag, strobe_cnt, target);
  endtask

  task automatic idle(input int n);
    Rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int g0;
    int lat;
    int gap;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_data_out", {24'd0, data_out}, 32'd0);
    check("rst_data_valid", {31'd0, data_valid}, 32'd0);
    check("rst_parity_err", {31'd0, parity_err}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(10);

    // Good frame with latency check
    send_frame(8'hA5, 1'b0, 1'b1);
    wait_strobes("strobe_a5", 1);
    lat = strobe_cyc[0] - start_cyc;
    check("latency_a5_in_284_286", {31'd0, (lat >= 284 && lat <= 286)}, 32'd1);
    idle(CPB);

    // Parity error, then a good frame clears it
    send_frame(8'h01, 1'b0, 1'b1);
    wait_strobes("strobe_01", 2);
    idle(CPB);
    send_frame(8'h3C, 1'b0, 1'b1);
    wait_strobes("strobe_3c", 3);
    idle(CPB);

    // Framing error followed by a held-low line
    send_frame(8'h7E, 1'b0, 1'b0);
    wait_strobes("strobe_7e", 4);
    repeat (5 * CPB) @(posedge clk);
    #1;
    check("break_busy", {31'd0, busy}, 32'd1);
    check("break_frame_err_held", {31'd0, frame_err}, 32'd1);
    check("break_data_held", {24'd0, data_out}, 32'h7E);
    idle(5);
    check("break_exit_busy", {31'd0, busy}, 32'd0);
    idle(2 * CPB);
    check("break_no_second_strobe", strobe_cnt, 4);

    // Short glitch is rejected
    g0 = cyc;
    Rx = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    Rx = 1'b1;
    check("glitch_busy_seen", {31'd0, busy}, 32'd1);
    while (busy && (cyc - g0) < 100) begin
      @(posedge clk);
      #1;
    end
    check("glitch_busy_clear_le_16", {31'd0, (cyc - g0) <= HALF + 3}, 32'd1);
    idle(2 * CPB);
    check("glitch_no_strobe", strobe_cnt, 4);

    // Back-to-back frames, no idle gap
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    wait_strobes("strobe_b2b", 6);
    gap = strobe_cyc[5] - strobe_cyc[4];
    check("b2b_gap_frame_len", {31'd0, (gap >= FRAME_CLK - 1 && gap <= FRAME_CLK + 1)}, 32'd1);
    idle(CPB);

    // Reset mid-frame aborts; next frame is received normally
    Rx = 1'b0;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(i[0] ? 1'b0 : 1'b1);
    Rx = 1'b1;
    repeat (HALF) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_data_out", {24'd0, data_out}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    idle(2 * CPB);
    check("abort_no_strobe", strobe_cnt, 6);
    send_frame(8'hC3, 1'b0, 1'b1);
    wait_strobes("strobe_c3", 7);
    idle(2 * CPB);

    check("scoreboard_empty", sb.size(), 0);
    check("total_strobes", strobe_cnt, 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
